// File: rtl/gamepad_receiver.sv
// rtl/gamepad_receiver.sv - NES/SNES serial pad receiver: latch/clock strobes, synchronised sampling, press-edge flags
module gamepad_receiver #(
  parameter int CLK_DIV         = 150,
  parameter int N_BITS          = 8,
  parameter int N_PADS          = 1,
  parameter bit ACTIVE_LOW_DATA = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       poll,
  input  logic [N_PADS-1:0]          pad_data,
  output logic                       pad_latch,
  output logic                       pad_clk,
  output logic                       busy,
  output logic                       valid,
  output logic [N_PADS*N_BITS-1:0]   buttons,
  output logic [N_PADS*N_BITS-1:0]   pressed
);

  localparam int CW = $clog2(2*CLK_DIV);
  localparam int KW = $clog2(N_BITS);
  localparam logic [CW-1:0] LAT_LAST  = CW'(2*CLK_DIV-1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV-1);
  localparam logic [KW-1:0] K_LAST    = KW'(N_BITS-1);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_LOW, S_HIGH, S_DONE} state_t;

  state_t                     r_state;
  logic [CW-1:0]              r_cnt;
  logic [KW-1:0]              r_k;
  logic [N_PADS-1:0]          r_sync1;
  logic [N_PADS-1:0]          r_sync2;
  logic [N_PADS*N_BITS-1:0]   r_shift;
  logic [N_PADS-1:0]          w_bit;

  assign w_bit = ACTIVE_LOW_DATA ? ~r_sync2 : r_sync2;

  // Strobes and busy follow the state one cycle later so every pin is a clean flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_k       <= '0;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_shift   <= '0;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      buttons   <= '0;
      pressed   <= '0;
    end else begin
      r_sync1   <= pad_data;
      r_sync2   <= r_sync1;
      pad_latch <= (r_state == S_LATCH);
      pad_clk   <= (r_state == S_HIGH);
      busy      <= (r_state != S_IDLE);
      valid     <= 1'b0;
      pressed   <= '0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_k   <= '0;
          if (poll) r_state <= S_LATCH;
        end
        S_LATCH: begin
          if (r_cnt == LAT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_LOW;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_LOW: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            for (int p = 0; p < N_PADS; p++) begin
              for (int j = 0; j < N_BITS; j++) begin
                if (r_k == KW'(j)) r_shift[p*N_BITS+j] <= w_bit[p];
              end
            end
            r_state <= (r_k == K_LAST) ? S_DONE : S_HIGH;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_HIGH: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt   <= '0;
            r_k     <= r_k + KW'(1);
            r_state <= S_LOW;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          buttons <= r_shift;
          pressed <= r_shift & ~buttons;
          valid   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/gamepad_receiver.md
Name: gamepad_receiver

Overview:
Parametrised serial game-controller receiver. It generates the latch and clock strobes for NES-style (8-bit) or SNES-style (16-bit) shift-register pads and reads one or more pads in parallel. It delivers debiased button words plus per-button press-edge pulses to the input controller. A poll is started once per frame from `frame_end` and drives the `uio_out[1:0]` latch/clock pins of the top level.

Parameters:
- `CLK_DIV`, 150: clk cycles per half-period of `pad_clk`; 6 us at 25 MHz. Legal range 4..1023.
- `N_BITS`, 8: bits shifted per pad; 8 = NES, 16 = SNES. Legal range 2..16.
- `N_PADS`, 1: number of pads read in parallel, sharing latch and clock. Legal range 1..4.
- `ACTIVE_LOW_DATA`, 1: 1 = raw line low means pressed, so the receiver inverts it. 0 = no inversion.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `poll`  in  1  start-read request; sampled on the rising edge of `clk`
- `pad_data`  in  `N_PADS`  serial data, one line per pad; asynchronous to `clk`
- `pad_latch`  out  1  parallel-load strobe to the pads
- `pad_clk`  out  1  shift clock to the pads
- `busy`  out  1  high while a read is in progress
- `valid`  out  1  one-cycle pulse when `buttons` has been updated
- `buttons`  out  `N_PADS*N_BITS`  held state; 1 = pressed
- `pressed`  out  `N_PADS*N_BITS`  rising-edge flags, valid only in the `valid` cycle and 0 otherwise

Behaviour:
- **Reset.** Asynchronous, active-low. While `rst_n`=0:
  - FSM is in IDLE.
  - `pad_latch`=0, `pad_clk`=0, `busy`=0, `valid`=0.
  - `buttons`=0, `pressed`=0.
  - Divider, bit counter, shift registers and synchroniser are all cleared.
  - A reset asserted mid-read aborts it immediately; no partial word is ever published.
- **Synchroniser.** Each `pad_data` line passes through a 2-FF synchroniser. All sampling uses the synchronised value.
  - If `ACTIVE_LOW_DATA`=1, the sampled bit is inverted before it is shifted in.
- **FSM states:** IDLE, LATCH, LOW, HIGH, DONE.
  - IDLE:
    - `poll`=1 moves to LATCH next cycle.
    - Divider count is loaded with 0 and bit index k with 0.
  - LATCH:
    - `pad_latch`=1 for exactly 2*`CLK_DIV` cycles, then go to LOW.
  - LOW:
    - `pad_clk`=0 for `CLK_DIV` cycles.
    - On the last cycle, sample bit k of every pad into `shift[p][k]`.
    - If k=`N_BITS`-1, go to DONE; else go to HIGH.
  - HIGH:
    - `pad_clk`=1 for `CLK_DIV` cycles, then k increments and the FSM returns to LOW.
    - This gives exactly `N_BITS`-1 rising edges of `pad_clk` per read.
  - DONE, one cycle:
    - `buttons` <= shift.
    - `pressed` <= shift & ~old `buttons`.
    - `valid`=1.
    - Next state is IDLE.
- **busy** is 1 in LATCH, LOW, HIGH and DONE, and 0 in IDLE. It is a registered output.
- **Bit mapping.** Bit k of pad p goes to `buttons[p*N_BITS+k]`.
  - NES order for k = 0..7: A, B, Select, Start, Up, Down, Left, Right.
  - SNES order for k = 0..15: B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R, then 4 bits reserved.
- **Latency.** `poll` high at edge t gives:
  - `pad_latch` rises at t+1.
  - `valid` is high in cycle t+1+(2*`N_BITS`+1)*`CLK_DIV`.
- **poll while busy**, including in the DONE cycle: ignored, with no queueing.
- **poll held high continuously:** back-to-back reads, with one IDLE cycle between DONE and the next LATCH.
- **Outputs outside the DONE cycle.** `buttons` holds between reads; `pressed` and `valid` are 0 in every other cycle.
- **Divider counter width:** clog2(2*`CLK_DIV`). Bit index width: clog2(`N_BITS`).
- **Timing.** `pad_latch` and `pad_clk` are registered and glitch-free, and are never high simultaneously.

Test Plan:
1. Reset mid-read, with `CLK_DIV`=4, `N_BITS`=8:
   - Stimulus: drop `rst_n` during HIGH.
   - Response: `pad_latch`/`pad_clk`/`busy`/`valid` go to 0 without waiting for a clk edge, and `buttons` goes to 0.
   - After release plus a poll: a full 8-bit read, with `valid` at t+69.
2. Single NES pad, `ACTIVE_LOW_DATA`=1:
   - Stimulus: pad model drives raw 8'b1110_1110, where bit k is output after latch plus k clock edges.
   - Response: `buttons`=8'h11 (A and Up pressed), `pressed`=8'h11 on the first read. On a second identical read, `pressed`=0.
   - Waveform: 2*4-cycle latch pulse, then 7 `pad_clk` pulses each 4 high and 4 low.
3. SNES, with `N_BITS`=16, `N_PADS`=2, `CLK_DIV`=4:
   - Stimulus: pad 0 raw 16'hFFFE, pad 1 raw 16'h7FFF.
   - Response: `buttons`=32'h8000_0001, 15 clock pulses, `valid` at t+133.
4. Poll collision:
   - Stimulus: assert `poll` at t+10 and in the DONE cycle of a running read.
   - Response: exactly one `valid` pulse, and `pad_latch` does not rise again until a later poll.
5. Continuous poll with `CLK_DIV`=4, `N_BITS`=8:
   - Response: `valid` pulses every 70 cycles, each followed by exactly one IDLE cycle before `pad_latch` rises.
6. Release edge:
   - Stimulus: read A pressed, then a read with A released.
   - Response: `buttons`[0] goes from 1 to 0 and `pressed`[0] stays 0 on both reads after the first.
